// File: rtl/sipo_deserializer.sv
// MSB-first serial-in, parallel-out deserializer with START framing,
// ready/valid output handshake and one-cycle OVERRUN / FRAME_ERR pulses.
module sipo_deserializer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SIN,
    input  logic             SIN_VALID,
    input  logic             START,
    output logic [WIDTH-1:0] DOUT,
    output logic             DOUT_VALID,
    input  logic             DOUT_READY,
    output logic             OVERRUN,
    output logic             FRAME_ERR
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic [4:0] LP_LAST = 5'(WIDTH - 1);

    state_t           r_state;
    logic [4:0]       r_bcnt;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_overrun;
    logic             r_frame_err;

    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] w_first;

    assign w_word  = {r_sr[WIDTH-2:0], SIN};
    assign w_first = {{(WIDTH-1){1'b0}}, SIN};

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state      <= ST_IDLE;
            r_bcnt       <= '0;
            r_sr         <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overrun    <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            if (DOUT_READY) begin
                r_dout_valid <= 1'b0;
            end
            if (SIN_VALID) begin
                case (r_state)
                    ST_IDLE: begin
                        if (START) begin
                            r_sr    <= w_first;
                            r_bcnt  <= 5'd1;
                            r_state <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT: begin
                        if (START) begin
                            // Restart mid-frame: drop partial word, new bit is bit 1
                            r_sr        <= w_first;
                            r_bcnt      <= 5'd1;
                            r_frame_err <= 1'b1;
                        end else if (r_bcnt == LP_LAST) begin
                            // Completion overrides the ready-clear issued above
                            r_dout       <= w_word;
                            r_dout_valid <= 1'b1;
                            r_overrun    <= r_dout_valid & ~DOUT_READY;
                            r_sr         <= '0;
                            r_bcnt       <= '0;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_sr   <= w_word;
                            r_bcnt <= r_bcnt + 5'd1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign DOUT       = r_dout;
    assign DOUT_VALID = r_dout_valid;
    assign OVERRUN    = r_overrun;
    assign FRAME_ERR  = r_frame_err;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed, table-driven bench for sipo_deserializer at WIDTH=8.
module tb_sipo_deserializer;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST;
    logic         SIN;
    logic         SIN_VALID;
    logic         START;
    logic         DOUT_READY;
    logic [W-1:0] DOUT;
    logic         DOUT_VALID;
    logic         OVERRUN;
    logic         FRAME_ERR;

    sipo_deserializer #(.WIDTH(W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .SIN        (SIN),
        .SIN_VALID  (SIN_VALID),
        .START      (START),
        .DOUT       (DOUT),
        .DOUT_VALID (DOUT_VALID),
        .DOUT_READY (DOUT_READY),
        .OVERRUN    (OVERRUN),
        .FRAME_ERR  (FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      name;
        logic       rst;
        logic       sv;
        logic       st;
        logic       sin;
        logic       rdy;
        logic [7:0] edout;
        logic       evalid;
        logic       eovr;
        logic       eferr;
        logic       chkd;
    } vec_t;

    vec_t q[$];
    int   n_run  = 0;
    int   n_fail = 0;

    task automatic v(input string nm, input logic rst, input logic sv, input logic st,
                     input logic sin, input logic rdy, input logic [7:0] ed,
                     input logic evd, input logic eo, input logic ef, input logic chkd);
        vec_t t;
        t.name = nm; t.rst = rst; t.sv = sv; t.st = st; t.sin = sin; t.rdy = rdy;
        t.edout = ed; t.evalid = evd; t.eovr = eo; t.eferr = ef; t.chkd = chkd;
        q.push_back(t);
    endtask

    // Pushes bits w[hi] down to w[lo]; outputs are expected to stay at ed/evd.
    // Gap cycles (SIN_VALID=0) carry START=1 and inverted SIN as don't-care noise.
    task automatic bits(input string nm, input logic [7:0] w, input int hi, input int lo,
                        input logic first_start, input logic rdy, input logic gaps,
                        input logic [7:0] ed, input logic evd, input logic chkd);
        for (int i = hi; i >= lo; i--) begin
            v(nm, 1'b1, 1'b1, first_start && (i == hi), w[i], rdy, ed, evd, 1'b0, 1'b0, chkd);
            if (gaps) begin
                for (int g = 0; g <= (i % 3); g++)
                    v(nm, 1'b1, 1'b0, 1'b1, ~w[i], rdy, ed, evd, 1'b0, 1'b0, chkd);
            end
        end
    endtask

    task automatic drive(input logic rst, input logic sv, input logic st,
                         input logic sin, input logic rdy);
        @(negedge CLK);
        RST = rst; SIN_VALID = sv; START = st; SIN = sin; DOUT_READY = rdy;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string nm, input logic [7:0] ed, input logic evd,
                         input logic eo, input logic ef, input logic chkd);
        n_run++;
        if ((chkd && DOUT !== ed) || DOUT_VALID !== evd || OVERRUN !== eo || FRAME_ERR !== ef) begin
            n_fail++;
            $display("FAIL %s: got DOUT=%h V=%b OVR=%b FERR=%b, want DOUT=%h(chk=%b) V=%b OVR=%b FERR=%b",
                     nm, DOUT, DOUT_VALID, OVERRUN, FRAME_ERR, ed, chkd, evd, eo, ef);
        end
    endtask

    initial begin
        logic [7:0] w81;
        RST = 1'b0; SIN = 1'b0; SIN_VALID = 1'b0; START = 1'b0; DOUT_READY = 1'b0;

        // Reset overrides active inputs
        v("reset0", 0, 1, 1, 1, 0, 8'h00, 0, 0, 0, 1);
        v("reset1", 0, 1, 1, 1, 1, 8'h00, 0, 0, 0, 1);
        // Valid bit without START in IDLE is ignored
        v("idle_nostart", 1, 1, 0, 1, 1, 8'h00, 0, 0, 0, 1);

        // Basic frame B2, ready held high
        bits("b2_bits", 8'hB2, 7, 1, 1, 1, 0, 8'h00, 0, 1);
        v("b2_done", 1, 1, 0, 0, 1, 8'hB2, 1, 0, 0, 1);
        v("b2_consumed", 1, 0, 0, 0, 1, 8'hB2, 0, 0, 0, 0);
        v("ready_no_valid", 1, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0);

        // Same frame with 1-3 cycle gaps, ready low
        bits("gap_bits", 8'hB2, 7, 1, 1, 0, 1, 8'h00, 0, 0);
        v("gap_done", 1, 1, 0, 0, 0, 8'hB2, 1, 0, 0, 1);
        v("gap_hold1", 1, 0, 0, 0, 0, 8'hB2, 1, 0, 0, 1);
        v("gap_hold2", 1, 1, 0, 1, 0, 8'hB2, 1, 0, 0, 1);

        // Overrun: 5A overwrites unconsumed B2
        bits("ovr_bits", 8'h5A, 7, 1, 1, 0, 0, 8'hB2, 1, 1);
        v("ovr_done", 1, 1, 0, 0, 0, 8'h5A, 1, 1, 0, 1);
        v("ovr_pulse_end", 1, 0, 0, 0, 0, 8'h5A, 1, 0, 0, 1);
        v("ovr_consume", 1, 0, 0, 0, 1, 8'h5A, 0, 0, 0, 0);

        // Abort after 3 bits, restart with C3
        bits("ferr_partial", 8'hFF, 7, 5, 1, 1, 0, 8'h00, 0, 0);
        v("ferr_restart", 1, 1, 1, 1, 1, 8'h00, 0, 0, 1, 0);
        bits("ferr_bits", 8'hC3, 6, 1, 0, 1, 0, 8'h00, 0, 0);
        v("ferr_done", 1, 1, 0, 1, 1, 8'hC3, 1, 0, 0, 1);
        v("ferr_consume", 1, 0, 0, 0, 1, 8'hC3, 0, 0, 0, 0);

        // Reset mid-frame, then clean 3C; then reset while holding a word
        bits("rst_partial", 8'hFF, 7, 3, 1, 1, 0, 8'h00, 0, 0);
        v("rst_mid", 0, 1, 1, 1, 1, 8'h00, 0, 0, 0, 1);
        bits("rst_bits", 8'h3C, 7, 1, 1, 0, 0, 8'h00, 0, 1);
        v("rst_3c_done", 1, 1, 0, 0, 0, 8'h3C, 1, 0, 0, 1);
        v("rst_with_word", 0, 1, 1, 1, 0, 8'h00, 0, 0, 0, 1);

        // Completion with ready on the same edge as an existing word
        bits("same_b2", 8'hB2, 7, 1, 1, 0, 0, 8'h00, 0, 1);
        v("same_b2_done", 1, 1, 0, 0, 0, 8'hB2, 1, 0, 0, 1);
        bits("same_0f", 8'h0F, 7, 1, 1, 0, 0, 8'hB2, 1, 1);
        v("same_0f_done", 1, 1, 0, 1, 1, 8'h0F, 1, 0, 0, 1);
        v("same_consume", 1, 0, 0, 0, 1, 8'h0F, 0, 0, 0, 0);

        // Back-to-back frames A5, 96 with START on the cycle after completion
        bits("b2b_a5", 8'hA5, 7, 1, 1, 1, 0, 8'h00, 0, 0);
        v("b2b_a5_done", 1, 1, 0, 1, 1, 8'hA5, 1, 0, 0, 1);
        v("b2b_96_start", 1, 1, 1, 1, 1, 8'h00, 0, 0, 0, 0);
        bits("b2b_96", 8'h96, 6, 1, 0, 1, 0, 8'h00, 0, 0);
        v("b2b_96_done", 1, 1, 0, 0, 0, 8'h96, 1, 0, 0, 1);

        foreach (q[k]) begin
            drive(q[k].rst, q[k].sv, q[k].st, q[k].sin, q[k].rdy);
            check(q[k].name, q[k].edout, q[k].evalid, q[k].eovr, q[k].eferr, q[k].chkd);
        end

        // Repeated restarts: each pulse lasts one cycle even across a gap
        drive(1, 1, 1, 1, 1); check("rr_start",   8'h00, 0, 0, 0, 0);
        drive(1, 1, 1, 0, 1); check("rr_restart", 8'h00, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 1); check("rr_gap",     8'h00, 0, 0, 0, 0);
        drive(1, 1, 1, 1, 1); check("rr_again",   8'h00, 0, 0, 1, 0);
        w81 = 8'h81;
        for (int i = 6; i >= 0; i--) begin
            drive(1, 1, 0, w81[i], 1);
            if (i > 0) check("rr_bits", 8'h00, 0, 0, 0, 0);
            else       check("rr_done", 8'h81, 1, 0, 0, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, want completion");
        $fatal(1);
    end

endmodule

// File: doc/sipo_deserializer.md
SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 Parameter WIDTH, default 8: number of serial bits assembled into one parallel word; legal range 2..32.
REQ-002 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-003 RST  input  1  synchronous, active-low reset, sampled at posedge CLK.
REQ-004 SIN  input  1  serial data bit.
REQ-005 SIN_VALID  input  1  SIN carries a valid bit this cycle.
REQ-006 START  input  1  qualified by SIN_VALID; marks the current bit as the first bit of a frame.
REQ-007 DOUT  output  WIDTH  assembled parallel word, registered.
REQ-008 DOUT_VALID  output  1  DOUT holds an unconsumed word.
REQ-009 DOUT_READY  input  1  consumer accepts DOUT this cycle when DOUT_VALID=1.
REQ-010 OVERRUN  output  1  one-cycle pulse: an unconsumed word was overwritten.
REQ-011 FRAME_ERR  output  1  one-cycle pulse: a frame was aborted by a new START.

Function
REQ-012 Two states: IDLE and SHIFT; 5-bit bit counter BCNT; WIDTH-bit shift register SR.
REQ-013 Bits are MSB-first: each accepted bit is shifted into SR bit 0 and SR moves toward MSB; the first bit of a frame ends in DOUT[WIDTH-1].
REQ-014 IDLE: SIN_VALID=1 and START=1 loads the bit, sets BCNT=1, moves to SHIFT; SIN_VALID=1 with START=0 is ignored; SIN_VALID=0 makes START don't-care.
REQ-015 SHIFT: SIN_VALID=1 and START=0 shifts the bit in and increments BCNT; SIN_VALID=0 holds SR and BCNT unchanged (gaps are unlimited).
REQ-016 SHIFT completion: the bit that brings BCNT to WIDTH completes the word; on that edge the full word (including that bit) loads into DOUT, DOUT_VALID is set, BCNT clears, and state returns to IDLE.
REQ-017 Latency: DOUT and DOUT_VALID are valid in the cycle immediately after the edge that samples the last bit.
REQ-018 Throughput: a new START is accepted on the first cycle after completion; back-to-back frames sustain one word per WIDTH valid bits.
REQ-019 SHIFT with SIN_VALID=1 and START=1: the partial frame is discarded, FRAME_ERR pulses high for exactly one cycle, the bit becomes bit 1 of a new frame, BCNT=1, and state stays SHIFT.
REQ-020 Handshake: DOUT_VALID stays high and DOUT stays stable until a cycle with DOUT_READY=1; on that edge DOUT_VALID clears unless a new word completes on the same edge.
REQ-021 Completion with DOUT_VALID=1 and DOUT_READY=1 on the same edge: the new word loads, DOUT_VALID stays 1, and OVERRUN stays 0.
REQ-022 Completion with DOUT_VALID=1 and DOUT_READY=0: the new word overwrites DOUT, DOUT_VALID stays 1, and OVERRUN pulses high for exactly one cycle.
REQ-023 DOUT_READY while DOUT_VALID=0 has no effect.
REQ-024 OVERRUN and FRAME_ERR are registered, never combinational, and otherwise 0.

Reset
REQ-025 RST=0 at a posedge overrides all other inputs and sets: state IDLE, BCNT=0, SR=0, DOUT=0, DOUT_VALID=0, OVERRUN=0, FRAME_ERR=0.
REQ-026 Reset mid-frame discards the partial frame without a FRAME_ERR pulse; reset with DOUT_VALID=1 discards the word without an OVERRUN pulse.
REQ-027 Bits presented while RST=0 are ignored; the first START accepted after RST returns high begins a clean frame.

Verification (WIDTH=8)
REQ-028 START with bits 1,0,1,1,0,0,1,0 on 8 consecutive valid cycles, DOUT_READY=1 -> DOUT=8'hB2 and DOUT_VALID=1 on the cycle after bit 8, DOUT_VALID=0 the cycle after that.
REQ-029 Same bits with SIN_VALID low for 1-3 cycles between bits -> DOUT=8'hB2, no extra shifts, completion only on the 8th valid bit.
REQ-030 Frames 8'hB2 then 8'h5A with DOUT_READY=0 -> OVERRUN pulses for 1 cycle at the second completion, DOUT=8'h5A, DOUT_VALID=1.
REQ-031 3 bits, then START with bits of 8'hC3 -> FRAME_ERR pulses for 1 cycle at the restart, DOUT=8'hC3, OVERRUN=0.
REQ-032 RST=0 for 1 cycle after 5 bits -> all outputs 0 next cycle, no error pulses; next frame 8'h3C assembles correctly.
REQ-033 DOUT_VALID=1 (8'hB2), second frame 8'h0F completes with DOUT_READY=1 on the same edge -> DOUT=8'h0F, DOUT_VALID=1, OVERRUN=0.
